// File: rtl/synapse_weight_arbiter.sv
// synapse_weight_arbiter: shares one single-port weight RAM between NUM_REQ
// neuron-core readers (round-robin) and a host write port (priority with a
// bounded streak). Read responses return two cycles after the grant, tagged
// with the one-hot ID of the issuing core.
module synapse_weight_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned NUM_SYNAPSES = 219,
    parameter int unsigned HOST_MAX     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    input  logic                        host_wr_valid,
    input  logic [ADDR_W-1:0]           host_wr_addr,
    input  logic [DATA_W-1:0]           host_wr_data,
    output logic                        host_wr_ready,
    output logic                        host_wr_err,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STK_W = $clog2(HOST_MAX + 1);

    // Arbitration state
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [STK_W-1:0]   host_streak_q, host_streak_d;

    // Issue stage (T+1) and response stage (T+2)
    logic               mem_en_q, mem_we_q, host_err_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [NUM_REQ-1:0] s1_vld_q, s2_vld_q;
    logic               s1_err_q, s2_err_q;

    // Grant decode
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic               host_block;
    logic               core_gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   cand;
    logic [ADDR_W-1:0]  gnt_addr;
    logic               host_oor, core_oor;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    // Combinational grant: host first unless its streak is exhausted while cores wait
    always_comb begin
        req_ready     = '0;
        host_wr_ready = 1'b0;
        core_gnt      = 1'b0;
        gnt_idx       = '0;
        cand          = '0;
        host_block    = (32'(host_streak_q) >= HOST_MAX) && (|req_valid);
        if (!rst) begin
            if (host_wr_valid && !host_block) begin
                host_wr_ready = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
                    if (!core_gnt && req_valid[cand]) begin
                        core_gnt = 1'b1;
                        gnt_idx  = cand;
                    end
                end
                if (core_gnt) begin
                    req_ready[gnt_idx] = 1'b1;
                end
            end
        end
        gnt_addr = addr_arr[gnt_idx];
        host_oor = 32'(host_wr_addr) >= NUM_SYNAPSES;
        core_oor = 32'(gnt_addr) >= NUM_SYNAPSES;
    end

    // Next round-robin pointer and host streak counter
    always_comb begin
        ptr_d         = ptr_q;
        host_streak_d = host_streak_q;
        if (core_gnt) begin
            ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
        if (!host_wr_valid || core_gnt) begin
            host_streak_d = '0;
        end else if (host_wr_ready && (32'(host_streak_q) < HOST_MAX)) begin
            host_streak_d = host_streak_q + 1'b1;
        end
    end

    // Registered RAM issue and two-stage response tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            host_streak_q <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            host_err_q    <= 1'b0;
            s1_vld_q      <= '0;
            s1_err_q      <= 1'b0;
            s2_vld_q      <= '0;
            s2_err_q      <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            host_streak_q <= host_streak_d;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            host_err_q    <= 1'b0;
            s1_vld_q      <= '0;
            s1_err_q      <= 1'b0;
            if (host_wr_ready) begin
                if (host_oor) begin
                    host_err_q <= 1'b1;
                end else begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= host_wr_addr;
                    mem_wdata_q <= host_wr_data;
                end
            end else if (core_gnt) begin
                s1_vld_q <= req_ready;
                s1_err_q <= core_oor;
                if (!core_oor) begin
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= gnt_addr;
                end
            end
            s2_vld_q <= s1_vld_q;
            s2_err_q <= s1_err_q;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign host_wr_err = host_err_q;
    assign rsp_valid   = s2_vld_q;
    assign rsp_err     = s2_err_q;
    assign rsp_data    = ((s2_vld_q != '0) && !s2_err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_synapse_weight_arbiter.sv
// tb_synapse_weight_arbiter: directed bench with a behavioural weight RAM,
// a vector table for arbitration sequences and hand-written corner cases.
module tb_synapse_weight_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        host_wr_valid;
    logic [7:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic        host_wr_ready;
    logic        host_wr_err;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [256];

    int checks = 0;
    int errors = 0;

    synapse_weight_arbiter #(
        .NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .NUM_SYNAPSES(219), .HOST_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
        .host_wr_err(host_wr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, 1-cycle read latency; contents reloaded while rst is high
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'hC000 | 16'(i);
            ram[5] <= 16'h1234;
            for (int i = 0; i < 4; i++) ram[10+i] <= 16'hA000 | 16'(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0]  rv;
        logic        hv;
        logic [7:0]  ha;
        logic [15:0] hd;
        logic [3:0]  e_rr;
        logic        e_hr;
        logic [3:0]  e_rv;
        logic [15:0] e_rd;
    } vec_t;

    vec_t tbl [18];

    initial begin
        // Rows 0-9: four cores contending from reset; rows 10-17: host streak limit
        tbl[0]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h1, 1'b0, 4'h0, 16'h0};
        tbl[1]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h2, 1'b0, 4'h0, 16'h0};
        tbl[2]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h4, 1'b0, 4'h1, 16'hA000};
        tbl[3]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h8, 1'b0, 4'h2, 16'hA001};
        tbl[4]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h1, 1'b0, 4'h4, 16'hA002};
        tbl[5]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h2, 1'b0, 4'h8, 16'hA003};
        tbl[6]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h4, 1'b0, 4'h1, 16'hA000};
        tbl[7]  = '{4'hF, 1'b0, 8'd0,  16'h0,    4'h8, 1'b0, 4'h2, 16'hA001};
        tbl[8]  = '{4'h0, 1'b0, 8'd0,  16'h0,    4'h0, 1'b0, 4'h4, 16'hA002};
        tbl[9]  = '{4'h0, 1'b0, 8'd0,  16'h0,    4'h0, 1'b0, 4'h8, 16'hA003};
        tbl[10] = '{4'h2, 1'b1, 8'd20, 16'h5500, 4'h0, 1'b1, 4'h0, 16'h0};
        tbl[11] = '{4'h2, 1'b1, 8'd20, 16'h5500, 4'h0, 1'b1, 4'h0, 16'h0};
        tbl[12] = '{4'h2, 1'b1, 8'd20, 16'h5500, 4'h0, 1'b1, 4'h0, 16'h0};
        tbl[13] = '{4'h2, 1'b1, 8'd20, 16'h5500, 4'h0, 1'b1, 4'h0, 16'h0};
        tbl[14] = '{4'h2, 1'b1, 8'd20, 16'h5500, 4'h2, 1'b0, 4'h0, 16'h0};
        tbl[15] = '{4'h0, 1'b1, 8'd20, 16'h5500, 4'h0, 1'b1, 4'h0, 16'h0};
        tbl[16] = '{4'h0, 1'b0, 8'd0,  16'h0,    4'h0, 1'b0, 4'h2, 16'hA001};
        tbl[17] = '{4'h0, 1'b0, 8'd0,  16'h0,    4'h0, 1'b0, 4'h0, 16'h0};

        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        host_wr_valid = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;

        // Reset state: no grants even with requests pending
        tick();
        req_valid = 4'hF;
        host_wr_valid = 1'b1;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst host_wr_ready", 32'(host_wr_ready), 32'h0);
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst mem_addr", 32'(mem_addr), 32'h0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst host_wr_err", 32'(host_wr_err), 32'h0);
        tick();
        req_valid = '0;
        host_wr_valid = 1'b0;
        rst = 1'b0;

        // Single core read
        req_valid = 4'b0001;
        req_addr[7:0] = 8'd5;
        #1;
        chk("t1 req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("t1 mem_en", 32'(mem_en), 32'h1);
        chk("t1 mem_we", 32'(mem_we), 32'h0);
        chk("t1 mem_addr", 32'(mem_addr), 32'd5);
        chk("t1 early rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("t1 rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1 rsp_data", 32'(rsp_data), 32'h1234);
        chk("t1 rsp_err", 32'(rsp_err), 32'h0);
        tick();
        chk("t1 rsp_valid drop", 32'(rsp_valid), 32'h0);

        // Table: round-robin from reset, then host streak limit
        rst_pulse();
        for (int i = 0; i < 4; i++) req_addr[i*8 +: 8] = 8'(10 + i);
        for (int r = 0; r < 18; r++) begin
            req_valid     = tbl[r].rv;
            host_wr_valid = tbl[r].hv;
            host_wr_addr  = tbl[r].ha;
            host_wr_data  = tbl[r].hd;
            #1;
            chk($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(tbl[r].e_rr));
            chk($sformatf("row%0d host_wr_ready", r), 32'(host_wr_ready), 32'(tbl[r].e_hr));
            chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].e_rv));
            chk($sformatf("row%0d rsp_data", r), 32'(rsp_data), 32'(tbl[r].e_rd));
            tick();
        end

        // Out-of-range core read (ptr now at core 2)
        req_valid = 4'b0100;
        req_addr[23:16] = 8'd219;
        #1;
        chk("t4 req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("t4 mem_en", 32'(mem_en), 32'h0);
        tick();
        chk("t4 rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t4 rsp_err", 32'(rsp_err), 32'h1);
        chk("t4 rsp_data", 32'(rsp_data), 32'h0);
        tick();
        chk("t4 rsp_err clear", 32'(rsp_err), 32'h0);

        // Out-of-range host write
        host_wr_valid = 1'b1;
        host_wr_addr = 8'd250;
        host_wr_data = 16'h7777;
        #1;
        chk("t4 host_wr_ready", 32'(host_wr_ready), 32'h1);
        tick();
        host_wr_valid = 1'b0;
        #1;
        chk("t4 host_wr_err", 32'(host_wr_err), 32'h1);
        chk("t4 host mem_we", 32'(mem_we), 32'h0);
        chk("t4 host mem_en", 32'(mem_en), 32'h0);
        tick();
        chk("t4 host_wr_err pulse", 32'(host_wr_err), 32'h0);

        // Read-after-write: host writes at T, core 3 reads at T+1
        host_wr_valid = 1'b1;
        host_wr_addr = 8'd7;
        host_wr_data = 16'hBEEF;
        #1;
        chk("t5 host_wr_ready", 32'(host_wr_ready), 32'h1);
        tick();
        host_wr_valid = 1'b0;
        req_valid = 4'b1000;
        req_addr[31:24] = 8'd7;
        #1;
        chk("t5 req_ready", 32'(req_ready), 32'h8);
        chk("t5 mem_we", 32'(mem_we), 32'h1);
        chk("t5 mem_addr", 32'(mem_addr), 32'd7);
        chk("t5 mem_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        req_valid = '0;
        #1;
        chk("t5 rd mem_en", 32'(mem_en), 32'h1);
        chk("t5 rd mem_we", 32'(mem_we), 32'h0);
        tick();
        chk("t5 rsp_valid", 32'(rsp_valid), 32'h8);
        chk("t5 rsp_data", 32'(rsp_data), 32'hBEEF);
        tick();

        // Reset with a read in flight: response discarded, ptr back to 0
        req_valid = 4'b0001;
        req_addr[7:0] = 8'd5;
        #1;
        chk("t6 req_ready", 32'(req_ready), 32'h1);
        tick();
        rst = 1'b1;
        req_valid = '0;
        #1;
        chk("t6 rst req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t6 rsp_valid a", 32'(rsp_valid), 32'h0);
        tick();
        rst = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("t6 rsp_valid b", 32'(rsp_valid), 32'h0);
        chk("t6 first grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("t6 rsp_valid c", 32'(rsp_valid), 32'h0);
        tick();
        chk("t6 resumed rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t6 resumed rsp_data", 32'(rsp_data), 32'h1234);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
